// File: rtl/shared_package.sv
// rtl/shared_package.sv - default FIFO geometry and data word type
package shared_package;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_FIFO_DEPTH = 8;

    typedef logic [DEF_FIFO_WIDTH-1:0] fifo_data_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - FIFO storage array, one write port, one registered read port
module sync_fifo_mem #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy flags and status pulses
// Optional macro FIFO_ASSERT_EN compiles in embedded protocol assertions.
module sync_fifo
    import shared_package::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  almostfull,
    output logic                  empty,
    output logic                  almostempty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wr_ack_q, overflow_q, underflow_q;
    logic                  rd_valid_q;
    logic                  wr_accept, rd_accept;
    logic [FIFO_WIDTH-1:0] mem_rd_data;

    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign almostfull  = (count_q == CW'(FIFO_DEPTH - 1));
    assign empty       = (count_q == '0);
    assign almostempty = (count_q == CW'(1));

    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_accept;
            overflow_q  <= wr_en && full;
            underflow_q <= rd_en && empty;
            if (rd_accept) begin
                rd_valid_q <= 1'b1;
            end
        end
    end

    sync_fifo_mem #(
        .WIDTH  (FIFO_WIDTH),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (AW)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_accept),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (data_in),
        .rd_en_i   (rd_accept),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (mem_rd_data)
    );

    // The storage read register has no reset, so data_out reads zero until the first accepted read.
    assign data_out  = rd_valid_q ? mem_rd_data : '0;
    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifdef FIFO_ASSERT_EN
    a_count_max: assert property (@(posedge clk) disable iff (rst)
        count_q <= CW'(FIFO_DEPTH));
    a_full_empty: assert property (@(posedge clk) disable iff (rst)
        !(full && empty));
    a_overflow_cause: assert property (@(posedge clk) disable iff (rst)
        overflow |-> $past(wr_en && full));
    a_underflow_cause: assert property (@(posedge clk) disable iff (rst)
        underflow |-> $past(rd_en && empty));
    a_count_step: assert property (@(posedge clk) disable iff (rst)
        (count_q == $past(count_q)) ||
        (count_q == $past(count_q) + CW'(1)) ||
        (count_q == $past(count_q) - CW'(1)));
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - scoreboard bench for sync_fifo
module tb_sync_fifo;
    import shared_package::*;

    localparam int W = 16;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] data_out;
    logic         wr_ack, overflow, underflow;
    logic         full, almostfull, empty, almostempty;

    int checks = 0;
    int failures = 0;

    fifo_data_t   exp_q[$];
    int           m_count = 0;
    logic [W-1:0] m_dout = '0;
    logic         m_wack = 1'b0;
    logic         m_ovf = 1'b0;
    logic         m_udf = 1'b0;

    sync_fifo #(
        .FIFO_WIDTH (W),
        .FIFO_DEPTH (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .data_in     (data_in),
        .data_out    (data_out),
        .wr_ack      (wr_ack),
        .overflow    (overflow),
        .underflow   (underflow),
        .full        (full),
        .almostfull  (almostfull),
        .empty       (empty),
        .almostempty (almostempty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ":data_out"},    32'(data_out),    32'(m_dout));
        check({tag, ":wr_ack"},      32'(wr_ack),      32'(m_wack));
        check({tag, ":overflow"},    32'(overflow),    32'(m_ovf));
        check({tag, ":underflow"},   32'(underflow),   32'(m_udf));
        check({tag, ":full"},        32'(full),        32'(m_count == D));
        check({tag, ":almostfull"},  32'(almostfull),  32'(m_count == D - 1));
        check({tag, ":empty"},       32'(empty),       32'(m_count == 0));
        check({tag, ":almostempty"}, 32'(almostempty), 32'(m_count == 1));
        check({tag, ":count"},       32'(dut.count_q), 32'(m_count));
    endtask

    task automatic cycle(input logic w, input logic r, input logic [W-1:0] d, input string tag);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        m_wack  = w && (m_count < D);
        m_ovf   = w && (m_count == D);
        m_udf   = r && (m_count == 0);
        if (r && m_count > 0) begin
            m_dout = exp_q.pop_front();
            m_count--;
        end
        if (m_wack) begin
            exp_q.push_back(d);
            m_count++;
        end
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_outputs(tag);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_count = 0;
        m_dout  = '0;
        m_wack  = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;

        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, W'(i), "fill");
        cycle(1'b1, 1'b0, 16'hDEAD, "overflow");
        cycle(1'b0, 1'b0, '0, "idle_after_ovf");
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0, "drain");
        cycle(1'b0, 1'b1, '0, "underflow");
        cycle(1'b0, 1'b0, '0, "idle_after_udf");

        cycle(1'b1, 1'b1, 16'h00AA, "simul_empty");
        cycle(1'b0, 1'b1, '0, "read_aa");

        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, W'(16'h0100 + i), "prefill4");
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, W'(16'h0200 + i), "simul_wrap");
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, '0, "drain4");

        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, W'(16'h0400 + i), "fill_full");
        cycle(1'b1, 1'b1, 16'hBEEF, "simul_full");
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, '0, "drain_full");

        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, W'(16'h0300 + i), "fill5");
        cycle(1'b0, 1'b1, '0, "read_one");
        #2 rst = 1'b1;
        model_reset();
        #1 check_outputs("async_reset");
        #1 rst = 1'b0;
        @(negedge clk);
        check_outputs("post_reset");
        cycle(1'b0, 1'b1, '0, "udf_after_reset");
        cycle(1'b1, 1'b0, 16'h0055, "write_after_reset");
        cycle(1'b0, 1'b1, '0, "read_after_reset");

        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter: FIFO_WIDTH, 16, data word width in bits.
REQ-002 Parameter: FIFO_DEPTH, 8, number of storage entries (power of two, >= 4).
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: wr_en  input  1  write request.
REQ-006 Port: rd_en  input  1  read request.
REQ-007 Port: data_in  input  FIFO_WIDTH  write data.
REQ-008 Port: data_out  output  FIFO_WIDTH  registered read data.
REQ-009 Port: wr_ack  output  1  registered; previous-cycle write accepted.
REQ-010 Port: overflow  output  1  registered; previous-cycle write rejected (full).
REQ-011 Port: underflow  output  1  registered; previous-cycle read rejected (empty).
REQ-012 Port: full, almostfull, empty, almostempty  output  1 each  combinational occupancy flags.

Function
REQ-013 Occupancy counter count SHALL be $clog2(FIFO_DEPTH)+1 bits wide, range 0..FIFO_DEPTH.
REQ-014 Flags SHALL decode as: full = (count==FIFO_DEPTH); almostfull = (count==FIFO_DEPTH-1); empty = (count==0); almostempty = (count==1).
REQ-015 Write accepted when wr_en && !full: mem[wr_ptr]<=data_in, wr_ptr increments modulo FIFO_DEPTH, wr_ack<=1 next cycle.
REQ-016 Write attempted when wr_en && full: memory/pointer unchanged, wr_ack<=0, overflow<=1 next cycle.
REQ-017 Read accepted when rd_en && !empty: data_out<=mem[rd_ptr] (1-cycle latency), rd_ptr increments modulo FIFO_DEPTH.
REQ-018 Read attempted when rd_en && empty: data_out holds, underflow<=1 next cycle.
REQ-019 wr_ack, overflow, underflow SHALL each be single-cycle pulses, cleared in any cycle without the triggering condition.
REQ-020 Simultaneous wr_en && rd_en, 0<count<FIFO_DEPTH: both accepted, count unchanged.
REQ-021 Simultaneous, empty: write accepted, read rejected (underflow=1), count becomes 1.
REQ-022 Simultaneous, full: read accepted, write rejected (overflow=1), count becomes FIFO_DEPTH-1.
REQ-023 Pointer wrap from FIFO_DEPTH-1 to 0 SHALL be seamless; no entry lost or duplicated.
REQ-024 data_out SHALL hold its last value when no read is accepted.

Reset
REQ-025 rst=1 SHALL immediately clear wr_ptr, rd_ptr, count, data_out, wr_ack, overflow, underflow to 0 (empty=1, others 0).
REQ-026 Reset mid-operation SHALL discard all stored entries; memory contents need not be cleared.
REQ-027 First accepted write SHALL be the first rising edge with rst=0.

Configuration
REQ-028 Macro FIFO_ASSERT_EN defined: embedded concurrent assertions compiled in (count<=FIFO_DEPTH; full&&empty never; overflow only after wr_en&&full; underflow only after rd_en&&empty; count step in {-1,0,+1}), disabled during rst.
REQ-029 Macro undefined: no assertion code present; RTL behaviour identical.

Structure
REQ-030 shared_package SHALL hold FIFO_WIDTH/FIFO_DEPTH defaults and typedef fifo_data_t (logic [FIFO_WIDTH-1:0]).
REQ-031 Storage SHALL be one sub-module sync_fifo_mem (1 write port, 1 registered read port, no reset); pointers, counter, flags live in sync_fifo.

Verification
REQ-032 Reset, then 8 writes 0x0001..0x0008 -> wr_ack each cycle, almostfull after 7th, full after 8th, empty=0.
REQ-033 From full, write 0xDEAD -> overflow=1 one cycle, wr_ack=0, contents unchanged; then 8 reads -> data_out 0x0001..0x0008 in order.
REQ-034 From empty, rd_en=1 -> underflow=1 one cycle, data_out unchanged, empty=1.
REQ-035 Count=4, wr_en=rd_en=1 for 20 cycles with incrementing data -> count stays 4, pointers wrap, read order equals write order.
REQ-036 Empty, wr_en=rd_en=1 with 0x00AA -> wr_ack=1, underflow=1, count=1, almostempty=1.
REQ-037 Count=5, assert rst asynchronously mid-cycle -> all outputs reset before next edge, empty=1, next read underflows.
